// File: rtl/mux42_arbiter_pkg.sv
// Shared sizing, state encoding and the grant-selection helper for the
// four-input arbitrated multiplexer.
package mux42_arbiter_pkg;

    localparam int NR_REQ = 4;
    localparam int SEL_W  = 2;
    localparam int DATA_W = 2;

    // IDLE means the output register is empty; HOLD means it carries an
    // item that downstream has not taken yet.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } grant_t;

    // Picks the first eligible requester. Round-robin mode starts the scan at
    // ptr and relies on SEL_W-bit addition to wrap modulo NR_REQ; fixed mode
    // always starts at index 0. The loop runs from the far end downwards so
    // that the closest candidate is the last one written and therefore wins.
    function automatic grant_t pick_winner(
        input logic [NR_REQ-1:0] eligible,
        input logic [SEL_W-1:0]  ptr,
        input logic              rr_en
    );
        grant_t           result;
        logic [SEL_W-1:0] idx;
        result = '0;
        for (int i = NR_REQ - 1; i >= 0; i--) begin
            idx = rr_en ? ptr + SEL_W'(i) : SEL_W'(i);
            if (eligible[idx]) begin
                result.found = 1'b1;
                result.idx   = idx;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/mux42.sv
// Plain 4:1 data multiplexer feeding the arbiter's output register.
module mux42
    import mux42_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] din [NR_REQ-1:0],
    input  logic [SEL_W-1:0]  sel,
    output logic [DATA_W-1:0] dout
);

    assign dout = din[sel];

endmodule

// File: rtl/mux42_arbiter.sv
// Four-requester arbiter with a one-entry registered output. A grant loads the
// winner's index and data; the entry is held until downstream accepts it, and
// a new winner can be loaded in the same cycle so transfers can run back to back.
module mux42_arbiter
    import mux42_arbiter_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NR_REQ-1:0] req,
    input  logic [DATA_W-1:0] din [NR_REQ-1:0],
    output logic [NR_REQ-1:0] ack,
    output logic [SEL_W-1:0]  sel,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              busy
);

    state_t            state;
    state_t            state_next;
    logic [SEL_W-1:0]  ptr;
    logic              accept;
    logic              load;
    logic [NR_REQ-1:0] eligible;
    logic [DATA_W-1:0] mux_out;
    grant_t            win;

    assign dout_valid = (state == HOLD);
    assign busy       = dout_valid;
    assign accept     = dout_valid && dout_ready;

    // The requester being acknowledged has not yet presented its next item,
    // so its request is masked out of this cycle's arbitration.
    assign eligible = req & ~ack;
    assign win      = pick_winner(eligible, ptr, RR_EN);

    mux42 u_mux (
        .din  (din),
        .sel  (win.idx),
        .dout (mux_out)
    );

    // One-hot acknowledge for the entry leaving the output register this cycle.
    always_comb begin
        ack = '0;
        if (accept) begin
            ack[sel] = 1'b1;
        end
    end

    // Decide whether the output register takes a new winner and where the FSM goes.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (win.found) begin
                    load       = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (accept) begin
                    if (win.found) begin
                        load = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, output register and round-robin pointer; the pointer moves to
    // the slot after each new grant so that slot is scanned first next time.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sel   <= '0;
            dout  <= '0;
            ptr   <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                sel  <= win.idx;
                dout <= mux_out;
                ptr  <= win.idx + SEL_W'(1);
            end
        end
    end

endmodule

// File: doc/mux42_arbiter.md
MUX42_ARBITER -- requirements
Module: mux42_arbiter

Interface
REQ-001 The block SHALL have parameter RR_EN, default 1, where 1 selects round-robin priority and 0 selects fixed priority with req[0] highest.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port req  input  4  per-requester request; bit k asks to transfer din[k].
REQ-005 The block SHALL have port din  input  4 x 2  per-requester data, unpacked array din[3:0].
REQ-006 The block SHALL have port ack  output  4  one-hot; bit k pulses in the cycle requester k's data is accepted downstream.
REQ-007 The block SHALL have port sel  output  2  registered index of the current grant.
REQ-008 The block SHALL have port dout  output  2  registered data of the current grant.
REQ-009 The block SHALL have port dout_valid  output  1  dout holds an untransferred item.
REQ-010 The block SHALL have port dout_ready  input  1  downstream accepts dout this cycle.
REQ-011 The block SHALL have port busy  output  1  equals dout_valid; provided for status LEDs.

Function
REQ-012 The FSM SHALL have two states: IDLE (dout_valid=0) and HOLD (dout_valid=1).
REQ-013 In IDLE with any req bit set, the block SHALL grant the winner, registering sel=winner and dout=din[winner], and enter HOLD on the next edge: one-cycle request-to-valid latency.
REQ-014 In IDLE with req=0, the block SHALL stay in IDLE with sel and dout unchanged.
REQ-015 In HOLD, sel, dout and dout_valid SHALL stay stable until dout_valid && dout_ready.
REQ-016 ack[k] SHALL be combinational: dout_valid && dout_ready && sel==k; all other bits 0.
REQ-017 On acceptance, with any req bit set excluding the just-acked bit, the block SHALL re-arbitrate in the same cycle and load the new winner, remaining in HOLD: one transfer per cycle sustained.
REQ-018 On acceptance with no eligible req, the block SHALL return to IDLE.
REQ-019 The just-acked requester's req SHALL be ignored in its ack cycle, because its next item is not yet presented; it is eligible again from the following cycle.
REQ-020 With RR_EN=1, the winner SHALL be the first set req bit scanning ptr, ptr+1, ... mod 4, where ptr=(last granted sel+1) mod 4, updated at each grant.
REQ-021 With RR_EN=0, the winner SHALL be the lowest-index set req bit, and ptr is unused.
REQ-022 A requester SHALL hold req and din stable until its ack; din changes after the grant edge SHALL NOT affect dout.
REQ-023 Deassertion of a granted requester's req before its ack SHALL NOT cancel the transfer: the item completes.
REQ-024 ptr wrap-around SHALL be modulo 4, so a grant at 3 gives ptr=0.

Reset
REQ-025 While rst=1 at an edge, the block SHALL set state=IDLE, sel=2'b00, dout=2'b00, dout_valid=0, busy=0 and ptr=0; ack is 0 because dout_valid=0.
REQ-026 Reset asserted in HOLD SHALL discard the pending item without an ack pulse.
REQ-027 In the first cycle after rst deasserts, the block SHALL arbitrate normally.

Structure
REQ-028 A shared package/include SHALL define NR_REQ=4, SEL_W=2, DATA_W=2 and the IDLE/HOLD state encoding.
REQ-029 Data selection SHALL use one instance of the existing mux42 (din, sel=next-winner index, dout -> dout register D input); no other sub-module.
REQ-030 The winner computation SHALL be a pure combinational function of req, ptr, RR_EN and the ack mask.

Verification
REQ-031 The bench SHALL cover reset then req=4'b0100, din[2]=2'b11, dout_ready=1: dout_valid rises 1 cycle later with sel=2, dout=11, ack=4'b0100 that cycle, then IDLE.
REQ-032 The bench SHALL cover req=4'b1111 held, dout_ready=1, RR_EN=1: sel sequence 0,1,2,3,0 on consecutive cycles, one ack per cycle.
REQ-033 The bench SHALL cover the same stimulus with RR_EN=0 and requester 0 dropping req after each ack for one cycle: sel sequence 0,1,0,1,...
REQ-034 The bench SHALL cover grant on 1 with dout_ready=0 for 5 cycles while din[1] toggles: dout, sel and dout_valid are constant, ack=0, then a single ack[1] when ready=1.
REQ-035 The bench SHALL cover rst=1 during HOLD: next cycle dout_valid=0, sel=0, dout=0, and no ack pulse at any time.
REQ-036 The bench SHALL cover ptr=3 with req=4'b1001: grant 3, then grant 0 on the next acceptance (wrap-around).
